// File: rtl/pi_fetch_ctrl.sv
// Pre-IF fetch controller: owns the fetch PC, arbitrates redirects and
// drives the synchronous instruction SRAM read address.
module pi_fetch_ctrl #(
  parameter int unsigned     PC_W       = 32,
  parameter logic [PC_W-1:0] RESET_PC   = PC_W'(32'h1C00_0000),
  parameter int unsigned     INST_BYTES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_allowin_i,
  output logic            pi_to_if_valid_o,
  output logic [PC_W-1:0] pi_to_if_obus,
  output logic            inst_sram_en_o,
  output logic [PC_W-1:0] inst_sram_addr_o,
  input  logic            br_taken_i,
  input  logic [PC_W-1:0] br_target_i,
  input  logic            excp_flush_i,
  input  logic [PC_W-1:0] excp_entry_i,
  input  logic            ertn_flush_i,
  input  logic [PC_W-1:0] era_i,
  output logic            redir_pending_o
);

  localparam logic [1:0] ST_RST   = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_REDIR = 2'd2;

  localparam logic [PC_W-1:0] PC_INC = PC_W'(INST_BYTES);

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_q, pend_d;
  logic            valid_q, valid_d;
  logic [PC_W-1:0] nextpc;
  logic            pi_allowin;
  logic            flush;
  logic            load;

  // Next-PC arbitration and load / stall / redirect-buffer decision
  always_comb begin
    flush      = excp_flush_i || ertn_flush_i;
    pi_allowin = !valid_q || if_allowin_i;

    if (excp_flush_i)             nextpc = excp_entry_i;
    else if (ertn_flush_i)        nextpc = era_i;
    else if (br_taken_i)          nextpc = br_target_i;
    else if (state_q == ST_REDIR) nextpc = pend_q;
    else                          nextpc = pc_q + PC_INC;

    // RST always loads: pc_q sits one increment below RESET_PC
    load = flush || (state_q == ST_RST) || pi_allowin;

    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    pend_d  = pend_q;

    if (load) begin
      pc_d    = nextpc;
      valid_d = 1'b1;
      state_d = ST_RUN;
    end else if (br_taken_i) begin
      // IF stalled: remember the target and kill the wrong-path PC
      pend_d  = br_target_i;
      valid_d = 1'b0;
      state_d = ST_REDIR;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RST;
      pc_q    <= RESET_PC - PC_INC;
      valid_q <= 1'b0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
    end
  end

  assign inst_sram_en_o   = load && rst_n;
  assign inst_sram_addr_o = nextpc;
  assign pi_to_if_valid_o = valid_q && rst_n;
  assign pi_to_if_obus    = pc_q;
  assign redir_pending_o  = (state_q == ST_REDIR);

endmodule

// File: doc/pi_fetch_ctrl.md
Name: pi_fetch_ctrl

Overview:
- Pre-IF (PI) stage controller. Holds the fetch PC, selects next PC and drives the synchronous instruction SRAM read.
- Presents {pc} to IF over the PiToIf bus with valid/allowin handshake. The SRAM data returns one cycle later, aligned with the registered PC.
- Arbitrates redirect sources by fixed priority: exception entry, ertn, taken branch, sequential +4.
- Buffers a branch redirect that arrives while IF is stalled.

Parameters:
PC_W, 32, PC/address width
RESET_PC, 32'h1C00_0000, first fetch address after reset
INST_BYTES, 4, sequential PC increment

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous reset, active-low
if_allowin_i  in  1  IF stage can accept this cycle
pi_to_if_valid_o  out  1  PI holds a valid PC for IF
pi_to_if_obus  out  PC_W  registered fetch PC (pc_q)
inst_sram_en_o  out  1  SRAM read enable (new address this cycle)
inst_sram_addr_o  out  PC_W  SRAM read address = nextpc
br_taken_i  in  1  taken branch/jump resolved downstream (1-cycle pulse)
br_target_i  in  PC_W  branch target
excp_flush_i  in  1  exception flush pulse from CSR/WB
excp_entry_i  in  PC_W  exception entry address (CSR EENTRY)
ertn_flush_i  in  1  ertn flush pulse
era_i  in  PC_W  return address (CSR ERA)
redir_pending_o  out  1  buffered branch redirect waiting (debug/perf)

Behaviour:
- Clock/reset: single clock clk; rst_n synchronous, active-low.
- Registers: pc_q, valid_q, state {RST, RUN, REDIR}, pend_target.
- Reset (rst_n=0 at edge): pc_q=RESET_PC-INST_BYTES, valid_q=0, state=RST, pend_target=0, redir_pending_o=0. While rst_n=0: inst_sram_en_o=0, pi_to_if_valid_o=0.
- pi_allowin = !valid_q || if_allowin_i. A PC is transferred to IF when valid_q && if_allowin_i.
- nextpc priority (combinational):
  1. excp_flush_i -> excp_entry_i
  2. ertn_flush_i -> era_i
  3. br_taken_i -> br_target_i
  4. state==REDIR -> pend_target
  5. otherwise pc_q+INST_BYTES (mod 2^PC_W; wraps at 0xFFFF_FFFC -> 0)
- Load condition:
  - excp_flush_i or ertn_flush_i: load unconditionally (younger stages are flushed). inst_sram_en_o=1, pc_q<=nextpc, valid_q<=1, state<=RUN, pending cleared.
  - else if pi_allowin and state!=RST: inst_sram_en_o=1, pc_q<=nextpc, valid_q<=1, state<=RUN.
  - RST: first cycle with rst_n=1 issues RESET_PC (en=1, valid_q<=1), state->RUN. Latency from reset release to first valid = 1 cycle.
  - else (stalled): en=0, pc_q and valid_q hold. SRAM output holds, so inst stays aligned with pc_q.
- inst_sram_addr_o = nextpc at all times. Meaningful only when en=1.
- Branch during stall (br_taken_i && !pi_allowin, no flush): pend_target<=br_target_i, state<=REDIR, valid_q<=0 (cancel wrong-path pc_q). The next cycle pi_allowin=1 and pend_target is fetched; state->RUN.
- Branch in REDIR: a new br_taken_i overrides pend_target (it is the younger, correct redirect).
- Flush while REDIR: flush target wins, pending discarded.
- Simultaneous excp_flush_i and ertn_flush_i: exception wins.
- redir_pending_o = (state==REDIR).
- No combinational path from br/flush inputs to pi_to_if_valid_o. Paths exist from those inputs to inst_sram_addr_o/en only.
- Mid-operation reset: all state returns to reset values at the next edge. Pending redirect is lost.

Test Plan:
- Reset release, if_allowin_i=1: addr sequence 0x1C000000, 0x1C000004, 0x1C000008. pi_to_if_obus lags addr by one cycle. First valid one cycle after rst_n rises.
- if_allowin_i=0 for 3 cycles with pc_q=0x1C000008: en=0, valid and pc_q hold. On release, addr=0x1C00000C.
- br_taken_i pulse (target 0x1C000100) while if_allowin_i=0: next cycle valid=0, redir_pending_o=1. Following cycle en=1, addr=0x1C000100. Then +4 sequence.
- excp_flush_i (entry 0x1C008000) together with br_taken_i and if_allowin_i=0: en=1, addr=0x1C008000 same cycle. Next cycle pc_q=0x1C008000, no pending.
- ertn_flush_i with era_i=0x1C000040 while in REDIR: addr=0x1C000040, redir_pending_o drops to 0.
- pc_q=0xFFFFFFFC, if_allowin_i=1: next addr=0x00000000.
